// File: rtl/hdmi_timing_gen_if.sv
// hdmi_timing_gen_if
//   Bundles the upstream pixel-fetch signals and the video outputs of
//   hdmi_timing_gen.
//   master : the timing generator (drives fetch request, sync, de, rgb)
//   slave  : upstream source / encoder side (drives pix_data, pattern_en)
//   Signals:
//     pix_req, pix_x[11:0], pix_y[11:0] : fetch request and coordinate
//     pix_data[23:0]                    : upstream RGB, one cycle latency
//     pattern_en                        : 1 = colour bars, 0 = pix_data
//     hsync, vsync, de, rgb[23:0]       : aligned encoder inputs
//     frame_start                       : one-cycle pulse per frame
interface hdmi_timing_gen_if;
   logic        pix_req;
   logic [11:0] pix_x;
   logic [11:0] pix_y;
   logic [23:0] pix_data;
   logic        pattern_en;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [23:0] rgb;
   logic        frame_start;

   modport master (
      input  pix_data, pattern_en,
      output pix_req, pix_x, pix_y, hsync, vsync, de, rgb, frame_start
   );

   modport slave (
      output pix_data, pattern_en,
      input  pix_req, pix_x, pix_y, hsync, vsync, de, rgb, frame_start
   );
endinterface

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen
//   Video timing generator for the HDMI TMDS encoders. Produces hsync/vsync,
//   de, 24-bit rgb and a frame_start pulse, all registered and aligned.
//   Pixel data comes from the upstream fetch port or an 8-bar pattern.
//   Ports:
//     sys_clk   : pixel clock
//     sys_rst_n : synchronous active-low reset
//     vid       : hdmi_timing_gen_if.master (fetch request + video outputs)
module hdmi_timing_gen #(
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BACK   = 48,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FRONT  = 16,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   hdmi_timing_gen_if.master  vid
);

   localparam logic [11:0] H_TOTAL   = 12'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
   localparam logic [11:0] V_TOTAL   = 12'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
   localparam logic [11:0] H_SYNC_W  = 12'(H_SYNC);
   localparam logic [11:0] V_SYNC_W  = 12'(V_SYNC);
   localparam logic [11:0] H_ACT_BEG = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] H_ACT_END = 12'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [11:0] V_ACT_BEG = 12'(V_SYNC + V_BACK);
   localparam logic [11:0] V_ACT_END = 12'(V_SYNC + V_BACK + V_ACTIVE);

   logic [11:0] cnt_h;
   logic [11:0] cnt_v;
   logic        h_active;
   logic        v_active;
   logic        first;
   logic        hs1;
   logic        vs1;
   logic        first1;
   logic        mode;
   logic [2:0]  bar;
   logic [23:0] bar_rgb;

   // Raster counters
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cnt_h <= '0;
         cnt_v <= '0;
      end else if (cnt_h == H_TOTAL - 12'd1) begin
         cnt_h <= '0;
         cnt_v <= (cnt_v == V_TOTAL - 12'd1) ? '0 : cnt_v + 12'd1;
      end else begin
         cnt_h <= cnt_h + 12'd1;
      end
   end

   always_comb begin
      h_active = (cnt_h >= H_ACT_BEG) && (cnt_h < H_ACT_END);
      v_active = (cnt_v >= V_ACT_BEG) && (cnt_v < V_ACT_END);
      first    = (cnt_h == '0) && (cnt_v == '0);
   end

   // Stage 1: fetch request and delayed sync flags.
   // The source select is sampled only at the first counter position so a
   // frame never mixes pattern and upstream pixels.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         vid.pix_req <= 1'b0;
         vid.pix_x   <= '0;
         vid.pix_y   <= '0;
         hs1         <= 1'b0;
         vs1         <= 1'b0;
         first1      <= 1'b0;
         mode        <= 1'b0;
      end else begin
         vid.pix_req <= h_active && v_active;
         vid.pix_x   <= (h_active && v_active) ? cnt_h - H_ACT_BEG : '0;
         vid.pix_y   <= (h_active && v_active) ? cnt_v - V_ACT_BEG : '0;
         hs1         <= cnt_h < H_SYNC_W;
         vs1         <= cnt_v < V_SYNC_W;
         first1      <= first;
         if (first) begin
            mode <= vid.pattern_en;
         end
      end
   end

   // Bar index: count of bar boundaries at or left of pix_x
   always_comb begin
      bar = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (vid.pix_x >= 12'(k * H_ACTIVE / 8)) begin
            bar = bar + 3'd1;
         end
      end
   end

   always_comb begin
      bar_rgb = '0;
      unique case (bar)
         3'd0: bar_rgb = 24'hFFFFFF;
         3'd1: bar_rgb = 24'hFFFF00;
         3'd2: bar_rgb = 24'h00FFFF;
         3'd3: bar_rgb = 24'h00FF00;
         3'd4: bar_rgb = 24'hFF00FF;
         3'd5: bar_rgb = 24'hFF0000;
         3'd6: bar_rgb = 24'h0000FF;
         3'd7: bar_rgb = 24'h000000;
         default: bar_rgb = '0;
      endcase
   end

   // Stage 2: aligned encoder outputs
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         vid.hsync       <= ~SYNC_POL;
         vid.vsync       <= ~SYNC_POL;
         vid.de          <= 1'b0;
         vid.rgb         <= '0;
         vid.frame_start <= 1'b0;
      end else begin
         vid.hsync       <= hs1 ? SYNC_POL : ~SYNC_POL;
         vid.vsync       <= vs1 ? SYNC_POL : ~SYNC_POL;
         vid.de          <= vid.pix_req;
         vid.frame_start <= first1;
         if (!vid.pix_req) begin
            vid.rgb <= '0;
         end else if (mode) begin
            vid.rgb <= bar_rgb;
         end else begin
            vid.rgb <= vid.pix_data;
         end
      end
   end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen
//   Small raster (H 4/3/16/2 = 25, V 2/2/6/1 = 11, frame = 275 clocks).
//   Stimulus pushes expected active-pixel colours per frame into a queue;
//   the monitor pops one entry on every de cycle, and checks sync/de/fetch
//   timing against a raster model indexed by edge number since reset.
module tb_hdmi_timing_gen;

   localparam int HS = 4, HB = 3, HA = 16, HF = 2;
   localparam int VS = 2, VB = 2, VA = 6, VF = 1;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FR = HT * VT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n = 0;
   int   checks = 0;
   int   failures = 0;
   logic [23:0] q[$];
   logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   hdmi_timing_gen_if vif ();

   hdmi_timing_gen #(
      .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
      .SYNC_POL(1'b0)
   ) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .vid      (vif)
   );

   always #5 clk = ~clk;

   // Edge number since reset release
   always @(posedge clk) n <= rst_n ? n + 1 : 0;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s edge=%0d got=%h expected=%h", nm, n, a, e);
      end
   endtask

   task automatic push_frame(input bit pat);
      logic [7:0] xb, yb;
      for (int y = 0; y < VA; y++) begin
         for (int x = 0; x < HA; x++) begin
            xb = 8'(x);
            yb = 8'(y);
            q.push_back(pat ? bar_tab[x / 2] : {yb, xb, 8'hA5});
         end
      end
   endtask

   // Upstream source: data for the presented coordinate, garbage otherwise
   always @(posedge clk) begin
      #1;
      if (vif.pix_req)
         vif.pix_data = {vif.pix_y[7:0], vif.pix_x[7:0], 8'hA5};
      else
         vif.pix_data = 24'($urandom);
   end

   // Monitor
   always @(posedge clk) begin
      int c, h, v;
      bit act;
      #1;
      if (n < 1) begin
         chk("pix_req_rst", 32'(vif.pix_req), 32'd0);
         chk("pix_x_rst", 32'(vif.pix_x), 32'd0);
         chk("pix_y_rst", 32'(vif.pix_y), 32'd0);
      end else begin
         c = n - 1; h = c % HT; v = (c / HT) % VT;
         act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
         chk("pix_req", 32'(vif.pix_req), 32'(act));
         chk("pix_x", 32'(vif.pix_x), act ? 32'(h - HS - HB) : 32'd0);
         chk("pix_y", 32'(vif.pix_y), act ? 32'(v - VS - VB) : 32'd0);
      end
      if (n < 2) begin
         chk("hsync_rst", 32'(vif.hsync), 32'd1);
         chk("vsync_rst", 32'(vif.vsync), 32'd1);
         chk("de_rst", 32'(vif.de), 32'd0);
         chk("fs_rst", 32'(vif.frame_start), 32'd0);
      end else begin
         c = n - 2; h = c % HT; v = (c / HT) % VT;
         act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
         chk("hsync", 32'(vif.hsync), (h < HS) ? 32'd0 : 32'd1);
         chk("vsync", 32'(vif.vsync), (v < VS) ? 32'd0 : 32'd1);
         chk("de", 32'(vif.de), 32'(act));
         chk("frame_start", 32'(vif.frame_start), 32'(c % FR == 0));
      end
      if (vif.de) begin
         if (q.size() == 0) begin
            chk("rgb_unexpected", 32'd1, 32'd0);
         end else begin
            chk("rgb", 32'(vif.rgb), 32'(q.pop_front()));
         end
      end else begin
         chk("rgb_blank", 32'(vif.rgb), 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog edge=%0d", n);
      $fatal(1, "timeout");
   end

   initial begin
      vif.pattern_en = 1'b0;
      vif.pix_data   = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_frame(1'b0);                // frame 0: pass-through
      repeat (100) @(negedge clk);     // mid frame 0
      vif.pattern_en = 1'b1;
      push_frame(1'b1);                // frame 1: colour bars
      repeat (325) @(negedge clk);     // frame 1, line 6
      vif.pattern_en = 1'b0;
      push_frame(1'b0);                // frame 2: back to pass-through
      repeat (305) @(negedge clk);     // frame 2, line 7
      rst_n = 1'b0;
      q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_frame(1'b0);
      push_frame(1'b0);
      repeat (2 * FR + 10) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
